score_tracker: RTL and testbench
================================

// Module: score_tracker
// PURPOSE
//   Accumulates the player's score during one song and feeds the high-score stage
//   downstream: provides the running score, the latched difficulty level and the
//   display/update mode.
//   Consumes per-arrow hit judgements from the arrow-timing logic.
//   Applies a combo multiplier and tracks the current and best combo.
//   Signals end-of-song with a one-cycle done pulse.
// PARAMETERS
//   PTS_PERFECT  10   base points for a perfect hit
//   PTS_GREAT    5    base points for a great hit
//   PTS_GOOD     2    base points for a good hit
//   COMBO_X2     10   combo count at which multiplier becomes x2
//   COMBO_X3     30   combo count at which multiplier becomes x3
// PORTS
//   clk          in   1   system clock, all logic on rising edge
//   rst          in   1   synchronous active-high reset
//   start        in   1   pulse: begin a song at level_sel
//   level_sel    in   2   requested level, 01/10/11 valid, 00 invalid
//   hit_valid    in   1   judgement strobe, one cycle per arrow
//   hit_grade    in   2   00 miss, 01 good, 10 great, 11 perfect
//   game_over    in   1   pulse: song finished
//   score        out  16  running score (high_score in_score)
//   level        out  2   level latched at start (high_score level)
//   hs_mode      out  1   1 = show stored high score, 0 = update (high_score mode)
//   combo        out  8   current consecutive non-miss count
//   max_combo    out  8   best combo this song
//   done         out  1   one-cycle pulse on entry to DONE
// BEHAVIOUR
//   Reset (sync, rst=1 at a rising edge):
//     - state=IDLE; score, combo, max_combo, level, done = 0; hs_mode = 1.
//     - Reset overrides all other inputs, including mid-song.
//   FSM states: IDLE, PLAY, DONE.
//     - IDLE -> PLAY: start=1 and level_sel!=00.
//         level<=level_sel; score, combo, max_combo <= 0; hs_mode<=0.
//     - start with level_sel=00 is ignored; state stays IDLE.
//     - PLAY -> DONE: game_over=1; done=1 for exactly that next cycle.
//     - DONE: score and level hold; hs_mode stays 0 so high_score captures the result.
//     - DONE -> PLAY: start with level_sel!=00 (same clears as from IDLE).
//     - DONE -> IDLE: start with level_sel=00; hs_mode<=1, score held.
//     - start while in PLAY is ignored.
//   Hit processing (PLAY only; hit_valid ignored in IDLE and DONE):
//     - mult = 1 if combo<COMBO_X2; 2 if combo<COMBO_X3; else 3.
//       mult uses the registered combo before this hit.
//     - Non-miss: score <= sat16(score + base*mult); combo <= combo+1, saturating at 255.
//       max_combo <= max(max_combo, new combo).
//     - Miss: combo <= 0; score and max_combo unchanged.
//     - Latency: score/combo reflect a hit on the cycle after the hit_valid edge.
//     - Saturation: sum computed at 18 bits and clamped to 16'hFFFF; no wrap.
//   Simultaneous events:
//     - hit_valid and game_over in the same cycle: hit is scored, then DONE.
//     - Back-to-back hit_valid on consecutive cycles: each is scored; no loss.
// TESTING
//   - rst, then start with level_sel=10 -> level=10, hs_mode=0, score=0, state PLAY.
//   - 3 perfect hits -> score=30, combo=3, max_combo=3.
//   - 12 great hits from reset-of-song -> 10*5 + 2*10 = 70; combo=12.
//   - 5 good, miss, 2 good -> score=14, combo=2, max_combo=5.
//   - score=65530 preloaded via hits, then perfect at combo>=30 -> score=65535 (sat).
//   - perfect + game_over in same cycle -> hit scored, done=1 one cycle, score holds.
//     Then assert rst mid-PLAY -> all outputs reset, hs_mode=1.

Source files
------------

// File: rtl/score_tracker.sv
// Per-song score accumulator with combo multiplier.
// Feeds score, latched level and display mode to the high-score stage.
module score_tracker #(
  parameter int unsigned PTS_PERFECT = 10,
  parameter int unsigned PTS_GREAT   = 5,
  parameter int unsigned PTS_GOOD    = 2,
  parameter int unsigned COMBO_X2    = 10,
  parameter int unsigned COMBO_X3    = 30
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  level_sel,
  input  logic        hit_valid,
  input  logic [1:0]  hit_grade,
  input  logic        game_over,
  output logic [15:0] score,
  output logic [1:0]  level,
  output logic        hs_mode,
  output logic [7:0]  combo,
  output logic [7:0]  max_combo,
  output logic        done
);

  localparam logic [7:0] BasePerf  = 8'(PTS_PERFECT);
  localparam logic [7:0] BaseGreat = 8'(PTS_GREAT);
  localparam logic [7:0] BaseGood  = 8'(PTS_GOOD);
  localparam logic [7:0] ComboX2   = 8'(COMBO_X2);
  localparam logic [7:0] ComboX3   = 8'(COMBO_X3);

  typedef enum logic [1:0] {
    IDLE,
    PLAY,
    DONE
  } state_e;

  state_e      state_q;
  logic [15:0] score_q;
  logic [1:0]  level_q;
  logic        hs_mode_q;
  logic [7:0]  combo_q;
  logic [7:0]  max_q;
  logic        done_q;

  logic [7:0]  base_d;
  logic [1:0]  mult_d;
  logic [9:0]  gain_d;
  logic [17:0] sum_d;
  logic [15:0] score_d;
  logic [7:0]  combo_d;
  logic [7:0]  max_d;
  logic        miss_d;
  logic        lvl_ok;

  assign lvl_ok = (level_sel != 2'b00);
  assign miss_d = (hit_grade == 2'b00);

  always_comb begin
    base_d = 8'd0;
    unique case (hit_grade)
      2'b11:   base_d = BasePerf;
      2'b10:   base_d = BaseGreat;
      2'b01:   base_d = BaseGood;
      default: base_d = 8'd0;
    endcase
    // Multiplier comes from the combo before this hit is counted.
    mult_d = 2'd3;
    if (combo_q < ComboX2) begin
      mult_d = 2'd1;
    end else if (combo_q < ComboX3) begin
      mult_d = 2'd2;
    end
    gain_d  = {2'b00, base_d} * {8'd0, mult_d};
    sum_d   = {2'b00, score_q} + {8'd0, gain_d};
    score_d = (sum_d[17:16] != 2'b00) ? 16'hFFFF : sum_d[15:0];
    combo_d = (combo_q == 8'hFF) ? 8'hFF : combo_q + 8'd1;
    max_d   = (combo_d > max_q) ? combo_d : max_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      score_q   <= 16'd0;
      level_q   <= 2'd0;
      hs_mode_q <= 1'b1;
      combo_q   <= 8'd0;
      max_q     <= 8'd0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start && lvl_ok) begin
            state_q   <= PLAY;
            level_q   <= level_sel;
            score_q   <= 16'd0;
            combo_q   <= 8'd0;
            max_q     <= 8'd0;
            hs_mode_q <= 1'b0;
          end
        end
        PLAY: begin
          if (hit_valid) begin
            if (miss_d) begin
              combo_q <= 8'd0;
            end else begin
              score_q <= score_d;
              combo_q <= combo_d;
              max_q   <= max_d;
            end
          end
          if (game_over) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          if (start && lvl_ok) begin
            state_q   <= PLAY;
            level_q   <= level_sel;
            score_q   <= 16'd0;
            combo_q   <= 8'd0;
            max_q     <= 8'd0;
            hs_mode_q <= 1'b0;
          end else if (start) begin
            state_q   <= IDLE;
            hs_mode_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign score     = score_q;
  assign level     = level_q;
  assign hs_mode   = hs_mode_q;
  assign combo     = combo_q;
  assign max_combo = max_q;
  assign done      = done_q;

endmodule

// File: tb/tb_score_tracker.sv
// Directed bench for score_tracker.
// Inputs change 1ns after a rising edge; outputs are checked there too.
module tb_score_tracker;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  level_sel;
  logic        hit_valid;
  logic [1:0]  hit_grade;
  logic        game_over;
  logic [15:0] score;
  logic [1:0]  level;
  logic        hs_mode;
  logic [7:0]  combo;
  logic [7:0]  max_combo;
  logic        done;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  score_tracker dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .level_sel (level_sel),
    .hit_valid (hit_valid),
    .hit_grade (hit_grade),
    .game_over (game_over),
    .score     (score),
    .level     (level),
    .hs_mode   (hs_mode),
    .combo     (combo),
    .max_combo (max_combo),
    .done      (done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic hit(input logic [1:0] g);
    hit_valid = 1'b1;
    hit_grade = g;
    tick();
    hit_valid = 1'b0;
  endtask

  task automatic go(input logic [1:0] l);
    start     = 1'b1;
    level_sel = l;
    tick();
    start     = 1'b0;
  endtask

  task automatic over();
    game_over = 1'b1;
    tick();
    game_over = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; level_sel = 2'b00;
    hit_valid = 1'b0; hit_grade = 2'b00; game_over = 1'b0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_score", 32'(score), 0);
    chk("rst_combo", 32'(combo), 0);
    chk("rst_max", 32'(max_combo), 0);
    chk("rst_level", 32'(level), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_hs", 32'(hs_mode), 1);

    go(2'b00);
    chk("bad_lvl_hs", 32'(hs_mode), 1);
    hit(2'b11);
    chk("idle_hit", 32'(score), 0);

    go(2'b10);
    chk("start_lvl", 32'(level), 2);
    chk("start_hs", 32'(hs_mode), 0);
    chk("start_score", 32'(score), 0);

    repeat (3) hit(2'b11);
    chk("perf3_score", 32'(score), 30);
    chk("perf3_combo", 32'(combo), 3);
    chk("perf3_max", 32'(max_combo), 3);

    over();
    chk("done_pulse", 32'(done), 1);
    tick();
    chk("done_clear", 32'(done), 0);
    chk("done_hold", 32'(score), 30);

    go(2'b11);
    chk("restart_score", 32'(score), 0);
    chk("restart_lvl", 32'(level), 3);
    repeat (12) hit(2'b10);
    chk("great12_score", 32'(score), 70);
    chk("great12_combo", 32'(combo), 12);
    hit(2'b00);
    chk("miss_combo", 32'(combo), 0);
    chk("miss_max", 32'(max_combo), 12);
    chk("miss_score", 32'(score), 70);
    go(2'b01);
    chk("play_start_lvl", 32'(level), 3);
    chk("play_start_score", 32'(score), 70);

    over();
    go(2'b01);
    repeat (5) hit(2'b01);
    hit(2'b00);
    repeat (2) hit(2'b01);
    chk("good_score", 32'(score), 14);
    chk("good_combo", 32'(combo), 2);
    chk("good_max", 32'(max_combo), 5);

    // 90 + 400 = 490 by combo 30, then 2168 x 30 reaches 65530.
    over();
    go(2'b10);
    repeat (2) hit(2'b10);
    repeat (28) hit(2'b11);
    chk("pre_score", 32'(score), 490);
    for (int i = 0; i < 2168; i++) hit(2'b11);
    chk("pre_sat", 32'(score), 65530);
    chk("combo_sat", 32'(combo), 255);
    chk("max_sat", 32'(max_combo), 255);
    hit(2'b11);
    chk("score_sat", 32'(score), 65535);
    hit(2'b01);
    chk("score_sat2", 32'(score), 65535);

    over();
    go(2'b10);
    hit(2'b11);
    chk("song_first", 32'(score), 10);
    game_over = 1'b1;
    hit(2'b11);
    game_over = 1'b0;
    chk("hit_go_score", 32'(score), 20);
    chk("hit_go_combo", 32'(combo), 2);
    chk("hit_go_done", 32'(done), 1);
    tick();
    chk("hit_go_done0", 32'(done), 0);
    chk("hit_go_hs", 32'(hs_mode), 0);
    hit(2'b11);
    chk("done_hit", 32'(score), 20);
    go(2'b00);
    chk("to_idle_hs", 32'(hs_mode), 1);
    chk("to_idle_score", 32'(score), 20);

    go(2'b01);
    repeat (2) hit(2'b10);
    chk("mid_score", 32'(score), 10);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst_score", 32'(score), 0);
    chk("mrst_combo", 32'(combo), 0);
    chk("mrst_max", 32'(max_combo), 0);
    chk("mrst_level", 32'(level), 0);
    chk("mrst_hs", 32'(hs_mode), 1);
    hit(2'b11);
    chk("mrst_idle", 32'(score), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
